// File: rtl/gate_alu_pipe_if.sv
// Handshake bundle for gate_alu_pipe.
// Input side: in_valid/in_ready/op/a/b. Output side: out_valid/out_ready/y.
interface gate_alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/gate_alu_pipe.sv
// Registered bitwise gate stage with a DEPTH-entry output FIFO.
// Ports: clk, rst (async high), bus (slave handshakes), done_cnt (pops).
module gate_alu_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  gate_alu_pipe_if.slave   bus,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      occ;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] res;

  // in_ready is a function of registered state and rst only.
  assign bus.in_ready  = !rst && (occ < FULL);
  assign bus.out_valid = (occ != '0);
  assign bus.y         = bus.out_valid ? mem[rp] : '0;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    res = '0;
    case (bus.op)
      3'd0: res = bus.a;
      3'd1: res = ~bus.a;
      3'd2: res = bus.a & bus.b;
      3'd3: res = bus.a | bus.b;
      3'd4: res = bus.a ^ bus.b;
      3'd5: res = ~(bus.a & bus.b);
      3'd6: res = ~(bus.a | bus.b);
      3'd7: res = ~(bus.a ^ bus.b);
      default: res = '0;
    endcase
  end

  // Storage needs no reset: occupancy alone decides visibility.
  always_ff @(posedge clk) begin
    if (accept) mem[wp] <= res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      occ      <= '0;
      done_cnt <= '0;
    end else begin
      if (accept) wp <= wp + 1'b1;
      if (pop) begin
        rp       <= rp + 1'b1;
        done_cnt <= done_cnt + 1'b1;
      end
      case ({accept, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_alu_pipe.sv
// Directed bench for gate_alu_pipe (WIDTH=8, DEPTH=2, CNT_W=4).
// Drives and samples on the falling clock edge.
module tb_gate_alu_pipe;
  logic       clk;
  logic       rst;
  logic [3:0] done_cnt;
  int         checks;
  int         failures;
  logic [7:0] sweep [8];
  logic [7:0] prev;
  logic [3:0] dexp;

  gate_alu_pipe_if #(.WIDTH(8)) bus ();

  gate_alu_pipe #(
    .WIDTH(8),
    .DEPTH(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gate(input logic [2:0] o,
                                      input logic [7:0] x,
                                      input logic [7:0] z);
    case (o)
      3'd0: return x;
      3'd1: return ~x;
      3'd2: return x & z;
      3'd3: return x | z;
      3'd4: return x ^ z;
      3'd5: return ~(x & z);
      3'd6: return ~(x | z);
      default: return ~(x ^ z);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] o,
                       input logic [7:0] x, input logic [7:0] z);
    bus.in_valid = v;
    bus.op = o;
    bus.a = x;
    bus.b = z;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sweep[0] = 8'hF0; sweep[1] = 8'h0F;
    sweep[2] = 8'h30; sweep[3] = 8'hFC;
    sweep[4] = 8'hCC; sweep[5] = 8'hCF;
    sweep[6] = 8'h03; sweep[7] = 8'h33;
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ov", 16'(bus.out_valid), 16'h0);
    chk("rst_ir", 16'(bus.in_ready), 16'h0);
    chk("rst_y", 16'(bus.y), 16'h0);
    chk("rst_cnt", 16'(done_cnt), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ir", 16'(bus.in_ready), 16'h1);
    chk("rel_ov", 16'(bus.out_valid), 16'h0);

    // op sweep
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), 8'hF0, 8'h3C);
      @(negedge clk);
      chk($sformatf("sweep_y%0d", k), 16'(bus.y), 16'(sweep[k]));
      chk($sformatf("sweep_ov%0d", k), 16'(bus.out_valid), 16'h1);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("sweep_end_ov", 16'(bus.out_valid), 16'h0);
    chk("sweep_cnt", 16'(done_cnt), 16'h8);

    // back-pressure
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd4, 8'h11, 8'h22);
    @(negedge clk);
    chk("bp_ir1", 16'(bus.in_ready), 16'h1);
    chk("bp_y1", 16'(bus.y), 16'h33);
    drive(1'b1, 3'd2, 8'hFF, 8'h5A);
    @(negedge clk);
    chk("bp_full_ir", 16'(bus.in_ready), 16'h0);
    chk("bp_hold_y", 16'(bus.y), 16'h33);
    drive(1'b1, 3'd6, 8'h0F, 8'h30);
    @(negedge clk);
    chk("bp_still_ir", 16'(bus.in_ready), 16'h0);
    chk("bp_still_y", 16'(bus.y), 16'h33);
    chk("bp_still_ov", 16'(bus.out_valid), 16'h1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_y2", 16'(bus.y), 16'h5A);
    chk("bp_ir_free", 16'(bus.in_ready), 16'h1);
    chk("bp_cnt9", 16'(done_cnt), 16'h9);
    @(negedge clk);
    chk("bp_y3", 16'(bus.y), 16'hC0);
    chk("bp_ov3", 16'(bus.out_valid), 16'h1);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("bp_empty", 16'(bus.out_valid), 16'h0);
    chk("bp_cnt11", 16'(done_cnt), 16'hB);

    // streaming, 100 random transactions
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)),
            8'($urandom), 8'($urandom));
      prev = gate(bus.op, bus.a, bus.b);
      @(negedge clk);
      chk($sformatf("st_y%0d", i), 16'(bus.y), 16'(prev));
      chk($sformatf("st_ov%0d", i), 16'(bus.out_valid), 16'h1);
      chk($sformatf("st_ir%0d", i), 16'(bus.in_ready), 16'h1);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("st_empty", 16'(bus.out_valid), 16'h0);
    chk("st_cnt", 16'(done_cnt), 16'hF);

    // mid-cycle reset with two results buffered
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd3, 8'h01, 8'h02);
    repeat (2) @(negedge clk);
    chk("pre_rst_full", 16'(bus.in_ready), 16'h0);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", 16'(bus.out_valid), 16'h0);
    chk("arst_y", 16'(bus.y), 16'h0);
    chk("arst_cnt", 16'(done_cnt), 16'h0);
    chk("arst_ir", 16'(bus.in_ready), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arel_ir", 16'(bus.in_ready), 16'h1);
    chk("arel_ov", 16'(bus.out_valid), 16'h0);

    // counter wrap across 17 transactions
    bus.out_ready = 1'b1;
    dexp = 4'h0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'd5, 8'(i), 8'hA5);
      @(negedge clk);
      if (i > 0) dexp = dexp + 4'h1;
      chk($sformatf("wr_cnt%0d", i), 16'(done_cnt), 16'(dexp));
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("wr_cnt_final", 16'(done_cnt), 16'h1);

    // pops while empty do nothing
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("ep_ov%0d", i), 16'(bus.out_valid), 16'h0);
      chk($sformatf("ep_y%0d", i), 16'(bus.y), 16'h0);
      chk($sformatf("ep_cnt%0d", i), 16'(done_cnt), 16'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
